imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Decodes every RV32I/RV64I immediate format: I, S, B, U and J.
- Reports the decoded format and an illegal-encoding flag, and computes the PC-relative target.
- Sits between the fetch buffer and the decode/ALU-operand stage, with valid/ready handshakes on both sides and a 2-entry skid buffer so it sustains one instruction per cycle under backpressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
EN_RV64, 0, when 1 (and XLEN=64) opcode 0011011 (OP-IMM-32) is decoded as I-type; otherwise that opcode is illegal.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  instruction presented.
in_ready  out  1  block can accept; 0 while rst_n=0.
in_instr  in  32  raw instruction.
in_pc  in  XLEN  PC of in_instr.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts.
out_imm  out  XLEN  sign-extended immediate.
out_fmt  out  3  0 NONE/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 reserved.
out_illegal  out  1  unknown opcode, or in_instr[1:0]!=2'b11.
out_target  out  XLEN  in_pc+imm for B, J and AUIPC; in_pc+4 otherwise.
out_pc  out  XLEN  passthrough of in_pc.

Behaviour:
- Decode uses opcode in_instr[6:0]:
  - I-type (0000011, 0010011, 1100111, 0011011 if EN_RV64): imm = sext(instr[31:20]).
  - S-type (0100011): imm = sext({[31:25],[11:7]}).
  - B-type (1100011): imm = sext({[31],[7],[30:25],[11:8],0}).
  - U-type (0110111, 0010111): imm = sext({[31:12],12'b0}); sign extension matters only for XLEN=64.
  - J-type (1101111): imm = sext({[31],[19:12],[20],[30:21],0}).
  - 0110011, 0111011, 0001111 and 1110011: fmt NONE, imm 0, legal.
  - Any other opcode, or [1:0]!=11: fmt NONE, imm 0, illegal=1.
- Target arithmetic is modulo 2^XLEN, with wrap-around and no overflow flag.
- Latency is exactly 1 cycle, from acceptance (in_valid & in_ready) to out_valid.
- State machine over the output register plus the skid entry:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1, skid holds the next result.
- Transitions:
  - EMPTY, accept → ONE.
  - ONE, accept with out_ready=1 → ONE; the output register reloads with the new result.
  - ONE, accept with out_ready=0 → FULL; the new result goes to skid.
  - ONE, no accept with out_ready=1 → EMPTY.
  - FULL, out_ready=1 → ONE; skid moves to the output register. No accept is possible in FULL.
- Outputs are held stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO.
- Reset, including mid-operation:
  - state EMPTY, skid discarded.
  - out_valid=0; out_imm, out_fmt, out_illegal, out_target and out_pc all 0.
  - in_ready=0 during reset and 1 on the first cycle after deassertion.
- in_instr and in_pc are ignored when in_valid=0.
- Simultaneous accept and consume in ONE gives continuous throughput; no bubble is inserted.

Optional Feature:
IMM_GEN_CSR_ZIMM_EN:
- When defined, for opcode 1110011 with funct3 in {101, 110, 111} (CSRRWI/CSRRSI/CSRRCI): out_fmt=6 and out_imm = zero-extended instr[19:15].
- When not defined, these instructions give fmt NONE, imm 0, illegal=0.
- Pipeline timing is identical either way.

Test Plan:
- Decode at XLEN=32 with out_ready=1, one instruction at a time:
  - 0x00412083 (LW) → imm 0x00000004, fmt 1.
  - 0xFFB10093 (ADDI x1,x2,-5) → imm 0xFFFFFFFB, fmt 1.
  - 0x00112423 (SW x1,8(x2)) → imm 0x00000008, fmt 2.
  - 0x123452B7 (LUI) → imm 0x12345000, fmt 4, target = pc+4.
  - Each result appears exactly 1 cycle after acceptance.
- Targets:
  - 0x00208863 (BEQ x1,x2,16) at pc 0x100 → imm 0x10, fmt 3, target 0x110.
  - 0xFFDFF06F (JAL x0,-4) at pc 0x0 → imm 0xFFFFFFFC, fmt 5, target 0xFFFFFFFC (wrap).
- Backpressure:
  - Hold out_ready=0 and stream LW, ADDI, SW → first two accepted, in_ready=0 from the cycle after the second accept, out_imm stable at 4.
  - Release out_ready → results emerge as 4, 0xFFFFFFFB, 8 on consecutive cycles, with no duplicates or drops.
- Illegal encodings:
  - 0x00000000 → fmt 0, imm 0, illegal=1.
  - 0x00000033 (ADD) → illegal=0.
  - 0x0000007F → illegal=1.
- Reset:
  - In FULL state, drive rst_n=0 for 1 cycle → next cycle out_valid=0, all outputs 0, in_ready=0.
  - After deassertion, in_ready=1 and the next instruction decodes correctly.
- CSR zimm, 0x3002D0F3 (CSRRWI x1,0x300,5):
  - With IMM_GEN_CSR_ZIMM_EN → imm 5, fmt 6.
  - Without it → imm 0, fmt 0, illegal=0.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and decode-side handshake bundle for imm_gen_pipe.
// Ports: in_valid/in_ready/in_instr/in_pc   (instruction in);
//        out_valid/out_ready/out_imm/out_fmt/out_illegal/out_target/out_pc (decoded result out).
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;

  // master: instruction producer and result consumer (surrounding pipeline)
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target, out_pc
  );

  // slave: the immediate generator itself
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target, out_pc
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Purpose: RV32I/RV64I immediate generator (I/S/B/U/J), format + illegal flag + PC-relative target.
// Latency: 1 cycle from acceptance to out_valid; one instruction per cycle sustained.
// Backpressure: output register plus one skid entry; in_ready drops only when both are occupied.
// Ports: clk, rst_n (synchronous, active-low); bus = imm_gen_pipe_if.slave
//   (in_valid/in_ready/in_instr/in_pc, out_valid/out_ready/out_imm/out_fmt/out_illegal/out_target/out_pc).
// Optional: define IMM_GEN_CSR_ZIMM_EN to decode CSRR*I zimm as format 6 (zero-extended rs1 field).
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int EN_RV64 = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_CSR_ZIMM_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
  } res_t;

  state_t state, state_nxt;
  res_t   dec, out_q, skid_q;
  logic   accept, load_out, load_skid, skid_to_out;

  // Every immediate is built as 32-bit signed, then sign-extended to XLEN by
  // the size cast; zimm is built with zero upper bits so it stays positive.
  logic signed [31:0] imm32;
  logic               pc_rel;
  logic [31:0]        ins;

  assign ins = bus.in_instr;

  always_comb begin
    imm32       = '0;
    pc_rel      = 1'b0;
    dec         = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    if (ins[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      unique case (ins[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: begin
          dec.fmt = FMT_I;
          imm32   = {{20{ins[31]}}, ins[31:20]};
        end
        7'b0011011: begin
          if ((EN_RV64 != 0) && (XLEN == 64)) begin
            dec.fmt = FMT_I;
            imm32   = {{20{ins[31]}}, ins[31:20]};
          end else begin
            dec.illegal = 1'b1;
          end
        end
        7'b0100011: begin
          dec.fmt = FMT_S;
          imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        end
        7'b1100011: begin
          dec.fmt = FMT_B;
          pc_rel  = 1'b1;
          imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        7'b0110111: begin
          dec.fmt = FMT_U;
          imm32   = {ins[31:12], 12'b0};
        end
        7'b0010111: begin
          dec.fmt = FMT_U;
          pc_rel  = 1'b1;  // AUIPC is the only U-type with a PC-relative target
          imm32   = {ins[31:12], 12'b0};
        end
        7'b1101111: begin
          dec.fmt = FMT_J;
          pc_rel  = 1'b1;
          imm32   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        7'b0110011, 7'b0111011, 7'b0001111: begin
          dec.fmt = FMT_NONE;
        end
        7'b1110011: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
          if (ins[14] && (ins[13:12] != 2'b00)) begin
            dec.fmt = FMT_Z;
            imm32   = {27'b0, ins[19:15]};
          end
`endif
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
    dec.imm    = XLEN'(imm32);
    dec.pc     = bus.in_pc;
    dec.target = bus.in_pc + (pc_rel ? dec.imm : XLEN'(4));
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset cycle,
  // not just from the edge after reset is sampled.
  assign bus.in_ready  = rst_n && (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt   = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
      end
      ONE: begin
        if (accept && bus.out_ready) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (bus.out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_nxt   = ONE;
          skid_to_out = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_out) begin
        out_q <= dec;
      end else if (skid_to_out) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_target  = out_q.target;
  assign bus.out_pc      = out_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe at XLEN=32: directed decode vectors,
// PC-relative targets with wrap, illegal encodings, backpressure through the
// skid entry, mid-operation reset, CSR zimm, and a random scoreboard run.
`timescale 1ns/1ps
module tb_imm_gen_pipe;
  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

  imm_gen_pipe #(.XLEN(XLEN), .EN_RV64(0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tgt;
    logic [31:0] pc;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  // Reference decode straight from the ISA field rules, using integer arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   s;
    logic rel;
    s   = signed'(ins);
    e   = '0;
    rel = 1'b0;
    e.pc = pc;
    if (ins[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (ins[6:0])
        7'h03, 7'h13, 7'h67: begin e.fmt = 3'd1; e.imm = s >>> 20; end
        7'h23: begin e.fmt = 3'd2; e.imm = (s >>> 25) * 32 + int'(ins[11:7]); end
        7'h63: begin
          e.fmt = 3'd3; rel = 1'b1;
          e.imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        end
        7'h37: begin e.fmt = 3'd4; e.imm = ins & 32'hFFFF_F000; end
        7'h17: begin e.fmt = 3'd4; rel = 1'b1; e.imm = ins & 32'hFFFF_F000; end
        7'h6F: begin
          e.fmt = 3'd5; rel = 1'b1;
          e.imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        end
        7'h33, 7'h3B, 7'h0F: e.fmt = 3'd0;
        7'h73: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
          if (int'(ins[14:12]) >= 5) begin e.fmt = 3'd6; e.imm = int'(ins[19:15]); end
`endif
        end
        default: e.ill = 1'b1;  // includes OP-IMM-32 with EN_RV64=0
      endcase
    end
    e.tgt = rel ? pc + e.imm : pc + 32'd4;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.imm = bus.out_imm;
    o.fmt = bus.out_fmt;
    o.ill = bus.out_illegal;
    o.tgt = bus.out_target;
    o.pc  = bus.out_pc;
    return o;
  endfunction

  // Present one instruction with out_ready=1 and capture what the DUT shows
  // one cycle after acceptance and one cycle after that.
  task automatic send_one(input logic [31:0] ins, input logic [31:0] pc,
                          output logic rdy, output logic vld, output exp_t got, output logic vld_after);
    logic [31:0] r;
    @(negedge clk);
    rdy           = bus.in_ready;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    @(negedge clk);
    r             = $urandom();
    bus.in_valid  = 1'b0;
    bus.in_instr  = r;              // junk while invalid must be ignored
    bus.in_pc     = r ^ 32'h5A5A_5A5A;
    vld           = bus.out_valid;
    got           = observe();
    @(negedge clk);
    vld_after     = bus.out_valid;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || observe() !== exp_t'(0)) begin
      n_err++;
      $display("FAIL reset_state in_ready=%b out_valid=%b outs=%h want 0/0/0", bus.in_ready, bus.out_valid, observe());
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic run_table(input string name, input logic [31:0] ins[], input logic [31:0] pcs[],
                           input logic [31:0] imms[], input logic [2:0] fmts[], input logic ills[],
                           input logic [31:0] tgts[]);
    logic rdy, vld, vld_after;
    exp_t got, e;
    for (int i = 0; i < ins.size(); i++) begin
      send_one(ins[i], pcs[i], rdy, vld, got, vld_after);
      e = '{imm: imms[i], fmt: fmts[i], ill: ills[i], tgt: tgts[i], pc: pcs[i]};
      n_vec++;
      if (rdy !== 1'b1 || vld !== 1'b1 || got !== e || vld_after !== 1'b0) begin
        n_err++;
        $display("FAIL %s[%0d] instr=%h rdy=%b vld=%b vld_after=%b got imm=%h fmt=%0d ill=%b tgt=%h pc=%h want imm=%h fmt=%0d ill=%b tgt=%h pc=%h (rdy/vld 1, vld_after 0)",
                 name, i, ins[i], rdy, vld, vld_after, got.imm, got.fmt, got.ill, got.tgt, got.pc,
                 e.imm, e.fmt, e.ill, e.tgt, e.pc);
      end
    end
  endtask

  task automatic test_decode();
    run_table("decode",
      '{32'h0041_2083, 32'hFFB1_0093, 32'h0011_2423, 32'h1234_52B7},
      '{32'h1000, 32'h1010, 32'h1020, 32'h1030},
      '{32'h0000_0004, 32'hFFFF_FFFB, 32'h0000_0008, 32'h1234_5000},
      '{3'd1, 3'd1, 3'd2, 3'd4},
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{32'h1004, 32'h1014, 32'h1024, 32'h1034});
  endtask

  task automatic test_targets();
    // BEQ +16, JAL -4 wrapping below zero, AUIPC wrapping past the top.
    run_table("target",
      '{32'h0020_8863, 32'hFFDF_F06F, 32'h0000_1517},
      '{32'h0000_0100, 32'h0000_0000, 32'hFFFF_F000},
      '{32'h0000_0010, 32'hFFFF_FFFC, 32'h0000_1000},
      '{3'd3, 3'd5, 3'd4},
      '{1'b0, 1'b0, 1'b0},
      '{32'h0000_0110, 32'hFFFF_FFFC, 32'h0000_0000});
  endtask

  task automatic test_illegal();
    run_table("illegal",
      '{32'h0000_0000, 32'h0000_0033, 32'h0000_007F, 32'h0000_001B},
      '{32'h40, 32'h44, 32'h48, 32'h4C},
      '{32'h0, 32'h0, 32'h0, 32'h0},
      '{3'd0, 3'd0, 3'd0, 3'd0},
      '{1'b1, 1'b0, 1'b1, 1'b1},
      '{32'h44, 32'h48, 32'h4C, 32'h50});
  endtask

  task automatic test_csr_zimm();
`ifdef IMM_GEN_CSR_ZIMM_EN
    run_table("csr_zimm", '{32'h3002_D0F3}, '{32'h80}, '{32'h5}, '{3'd6}, '{1'b0}, '{32'h84});
`else
    run_table("csr_zimm", '{32'h3002_D0F3}, '{32'h80}, '{32'h0}, '{3'd0}, '{1'b0}, '{32'h84});
`endif
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.in_instr = 32'h0041_2083; bus.in_pc = 32'h200;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'h4 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first vld=%b imm=%h in_ready=%b want 1/00000004/1", bus.out_valid, bus.out_imm, bus.in_ready);
    end
    bus.in_instr = 32'hFFB1_0093; bus.in_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_imm !== 32'h4) begin
        n_err++;
        $display("FAIL bp_hold[%0d] in_ready=%b vld=%b imm=%h want 0/1/00000004", k, bus.in_ready, bus.out_valid, bus.out_imm);
      end
      bus.in_instr = 32'h0011_2423; bus.in_pc = 32'h208;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'hFFFF_FFFB || bus.out_pc !== 32'h204 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drain1 vld=%b imm=%h pc=%h in_ready=%b want 1/fffffffb/00000204/1", bus.out_valid, bus.out_imm, bus.out_pc, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'h8 || bus.out_pc !== 32'h208) begin
      n_err++;
      $display("FAIL bp_drain2 vld=%b imm=%h pc=%h want 1/00000008/00000208", bus.out_valid, bus.out_imm, bus.out_pc);
    end
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [6] = '{32'h0041_2083, 32'h0020_8863, 32'hFFDF_F06F, 32'h0011_2423, 32'h1234_52B7, 32'h0000_0033};
    exp_t e;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        e = model(prog[i-1], 32'h3000 + 32'(4 * (i - 1)));
        n_vec++;
        if (bus.out_valid !== 1'b1 || observe() !== e) begin
          n_err++;
          $display("FAIL b2b[%0d] vld=%b got=%h want=%h", i - 1, bus.out_valid, observe(), e);
        end
      end
      if (i < 6) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready[%0d] in_ready=%b want 1", i, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_instr = prog[i]; bus.in_pc = 32'h3000 + 32'(4 * i);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_tail out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, vld, vld_after;
    exp_t got;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0041_2083; bus.in_pc = 32'h500;
    @(negedge clk);
    bus.in_instr = 32'hFFB1_0093; bus.in_pc = 32'h504;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_full in_ready=%b vld=%b want 0/1", bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || observe() !== exp_t'(0)) begin
      n_err++;
      $display("FAIL rst_mid_clear vld=%b in_ready=%b outs=%h want 0/0/0", bus.out_valid, bus.in_ready, observe());
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_release in_ready=%b vld=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    // The discarded skid entry (ADDI) must not reappear ahead of this SW.
    send_one(32'h0011_2423, 32'h600, rdy, vld, got, vld_after);
    n_vec++;
    if (rdy !== 1'b1 || vld !== 1'b1 || got !== model(32'h0011_2423, 32'h600) || vld_after !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_next rdy=%b vld=%b vld_after=%b got=%h want=%h", rdy, vld, vld_after, got, model(32'h0011_2423, 32'h600));
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [13] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h73};
    logic [31:0] ins, pc;
    exp_t        got, prev, e;
    logic        prev_hold;
    prev_hold = 1'b0;
    prev      = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      got = observe();
      if (prev_hold) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || got !== prev) begin
          n_err++;
          $display("FAIL rand_stable cyc=%0d vld=%b got=%h held=%h", cyc, bus.out_valid, got, prev);
        end
      end
      bus.out_ready = (cyc < 800) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_spurious cyc=%0d got=%h with nothing pending", cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, got, e);
          end
        end
      end
      prev_hold = (bus.out_valid === 1'b1) && !bus.out_ready;
      prev      = got;
      ins = $urandom();
      pc  = $urandom();
      if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 12)];
      bus.in_instr = ins;
      bus.in_pc    = pc;
      bus.in_valid = (cyc < 800) && ($urandom_range(0, 3) != 0);
      if (bus.in_valid && bus.in_ready === 1'b1) exp_q.push_back(model(ins, pc));
    end
    n_vec++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rand_drain pending=%0d out_valid=%b want 0/0", exp_q.size(), bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_decode();
    test_targets();
    test_illegal();
    test_csr_zimm();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
